// File: rtl/serv_irq_csr.sv
// rtl/serv_irq_csr.sv - bit-serial machine-mode interrupt CSRs (mstatus, mie, mip, mcause)
module serv_irq_csr #(
    parameter int NLIRQ    = 4,
    parameter int MCAUSE_W = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_init,
    input  logic                            i_en,
    input  logic [4:0]                      i_cnt,
    input  logic                            i_cnt_done,
    input  logic [2:0]                      i_csr_sel,
    input  logic [1:0]                      i_csr_source,
    input  logic                            i_d,
    input  logic                            i_trap,
    input  logic                            i_mret,
    input  logic                            i_e_op,
    input  logic                            i_ebreak,
    input  logic                            i_mem_op,
    input  logic                            i_mem_cmd,
    input  logic                            i_msip,
    input  logic                            i_mtip,
    input  logic                            i_meip,
    input  logic [(NLIRQ>0?NLIRQ:1)-1:0]    i_lirq,
    output logic                            o_q,
    output logic                            o_csr_in,
    output logic                            o_irq_pending,
    output logic                            o_new_irq,
    output logic                            o_mie
);

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888 | (((32'd1 << NLIRQ) - 32'd1) << 16);
    localparam logic [31:0] MCAUSE_MASK  = 32'h8000_0000 | ((32'd1 << MCAUSE_W) - 32'd1);

    // Registers are held as full words; only bits in the matching mask are ever written.
    logic [31:0] mstatus_r;
    logic [31:0] mie_r;
    logic [31:0] mcause_r;
    logic [4:0]  irq_code;
    logic        pend_r;

    logic [31:0] mip_vec;
    logic [31:0] enabled;
    logic [4:0]  next_code;
    logic [31:0] sel_vec;
    logic [31:0] wmask;
    logic [3:0]  exc_code;
    logic [31:0] trap_mcause;
    logic        wr;

    always_comb begin
        mip_vec     = '0;
        mip_vec[3]  = i_msip;
        mip_vec[7]  = i_mtip;
        mip_vec[11] = i_meip;
        for (int i = 0; i < NLIRQ; i++)
            mip_vec[16+i] = i_lirq[i];
    end

    assign enabled       = mip_vec & mie_r;
    assign o_mie         = mstatus_r[3];
    assign o_irq_pending = o_mie & (|enabled);

    // Lowest-priority sources are applied first so higher ones overwrite them.
    always_comb begin
        next_code = '0;
        for (int i = NLIRQ - 1; i >= 0; i--)
            if (enabled[16+i])
                next_code = 5'(16 + i);
        if (enabled[7])
            next_code = 5'd7;
        if (enabled[3])
            next_code = 5'd3;
        if (enabled[11])
            next_code = 5'd11;
    end

    always_comb begin
        sel_vec = '0;
        wmask   = '0;
        case (i_csr_sel)
            3'd1: begin sel_vec = mstatus_r; wmask = MSTATUS_MASK; end
            3'd2: begin sel_vec = mie_r;     wmask = MIE_MASK;     end
            3'd3: begin sel_vec = mip_vec;   wmask = '0;           end
            3'd4: begin sel_vec = mcause_r;  wmask = MCAUSE_MASK;  end
            default: begin sel_vec = '0;     wmask = '0;           end
        endcase
    end

    assign o_q = sel_vec[i_cnt];
    assign wr  = i_en & wmask[i_cnt];

    always_comb begin
        case (i_csr_source)
            2'd0:    o_csr_in = o_q;
            2'd1:    o_csr_in = i_d;
            2'd2:    o_csr_in = o_q | i_d;
            default: o_csr_in = o_q & ~i_d;
        endcase
    end

    always_comb begin
        exc_code = 4'd0;
        if (i_e_op)
            exc_code = i_ebreak ? 4'd3 : 4'd11;
        else if (i_mem_op)
            exc_code = i_mem_cmd ? 4'd6 : 4'd4;
        trap_mcause = o_new_irq ? {1'b1, 26'd0, irq_code} : {28'd0, exc_code};
        trap_mcause = trap_mcause & MCAUSE_MASK;
    end

    // Trap/mret assignments come last so they override a same-cycle CSR write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mstatus_r <= '0;
            mie_r     <= '0;
            mcause_r  <= '0;
            irq_code  <= '0;
            pend_r    <= 1'b0;
            o_new_irq <= 1'b0;
        end else begin
            if (wr) begin
                case (i_csr_sel)
                    3'd1:    mstatus_r[i_cnt] <= o_csr_in;
                    3'd2:    mie_r[i_cnt]     <= o_csr_in;
                    3'd4:    mcause_r[i_cnt]  <= o_csr_in;
                    default: ;
                endcase
            end
            if (i_cnt_done && !i_init) begin
                pend_r    <= o_irq_pending;
                o_new_irq <= o_irq_pending & ~pend_r;
                irq_code  <= next_code;
            end
            if (i_cnt_done && i_trap) begin
                mstatus_r[7] <= mstatus_r[3];
                mstatus_r[3] <= 1'b0;
                mcause_r     <= trap_mcause;
            end else if (i_cnt_done && i_mret) begin
                mstatus_r[3] <= mstatus_r[7];
                mstatus_r[7] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serv_irq_csr.sv
// tb/tb_serv_irq_csr.sv - scoreboard testbench for serv_irq_csr
module tb_serv_irq_csr;

    logic       i_clk = 1'b0;
    logic       i_rst, i_init, i_en, i_cnt_done, i_d;
    logic [4:0] i_cnt;
    logic [2:0] i_csr_sel;
    logic [1:0] i_csr_source;
    logic       i_trap, i_mret, i_e_op, i_ebreak, i_mem_op, i_mem_cmd;
    logic       i_msip, i_mtip, i_meip;
    logic [3:0] i_lirq;
    logic       o_q, o_csr_in, o_irq_pending, o_new_irq, o_mie;

    serv_irq_csr #(.NLIRQ(4), .MCAUSE_W(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt(i_cnt),
        .i_cnt_done(i_cnt_done), .i_csr_sel(i_csr_sel), .i_csr_source(i_csr_source),
        .i_d(i_d), .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op), .i_ebreak(i_ebreak),
        .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd), .i_msip(i_msip), .i_mtip(i_mtip),
        .i_meip(i_meip), .i_lirq(i_lirq), .o_q(o_q), .o_csr_in(o_csr_in),
        .o_irq_pending(o_irq_pending), .o_new_irq(o_new_irq), .o_mie(o_mie)
    );

    always #5 i_clk = ~i_clk;

    localparam int K_WORD = 0, K_PEND = 1, K_NEW = 2, K_MIE = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    sb_item_t    sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        rd_active = 1'b0;
    logic        chk_strobe = 1'b0;
    int          chk_kind = 0;
    logic [31:0] rd_word;

    task automatic check_item(input int kind, input logic [31:0] act);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            it = sb.pop_front();
            if (it.kind != kind || act !== it.exp) begin
                errors++;
                $display("FAIL %s: actual %h required %h", it.name, act, it.exp);
            end
        end
    endtask

    // Monitor: pops one expectation whenever a read word completes or a probe is strobed.
    always @(negedge i_clk) begin
        if (rd_active) begin
            rd_word[i_cnt] = o_q;
            if (i_cnt == 5'd31)
                check_item(K_WORD, rd_word);
        end
        if (chk_strobe) begin
            case (chk_kind)
                K_PEND:  check_item(K_PEND, {31'd0, o_irq_pending});
                K_NEW:   check_item(K_NEW,  {31'd0, o_new_irq});
                default: check_item(K_MIE,  {31'd0, o_mie});
            endcase
        end
    end

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic word(input logic [2:0] sel, input logic [1:0] src, input logic [31:0] d,
                        input logic rd, input logic trap, input logic mret);
        for (int i = 0; i < 32; i++) begin
            i_csr_sel    = sel;
            i_csr_source = src;
            i_cnt        = 5'(i);
            i_en         = 1'b1;
            i_d          = d[i];
            rd_active    = rd;
            @(posedge i_clk); #1;
        end
        i_en       = 1'b0;
        rd_active  = 1'b0;
        i_cnt_done = 1'b1;
        i_trap     = trap;
        i_mret     = mret;
        @(posedge i_clk); #1;
        i_cnt_done = 1'b0;
        i_trap     = 1'b0;
        i_mret     = 1'b0;
        i_csr_sel  = 3'd0;
        i_cnt      = 5'd0;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [1:0] src, input logic [31:0] d);
        word(sel, src, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string name);
        push(K_WORD, exp, name);
        word(sel, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk(input int kind, input logic exp, input string name);
        push(kind, {31'd0, exp}, name);
        chk_kind   = kind;
        chk_strobe = 1'b1;
        @(negedge i_clk); #1;
        chk_strobe = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_init = 1'b0; i_en = 1'b0; i_cnt = '0; i_cnt_done = 1'b0; i_d = 1'b0;
        i_csr_sel = '0; i_csr_source = '0; i_trap = 1'b0; i_mret = 1'b0;
        i_e_op = 1'b0; i_ebreak = 1'b0; i_mem_op = 1'b0; i_mem_cmd = 1'b0;
        i_msip = 1'b1; i_mtip = 1'b0; i_meip = 1'b0; i_lirq = '0;
        @(posedge i_clk); #1;
        rd(3'd3, 32'h0000_0008, "mip_during_reset");
        i_msip = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        chk(K_MIE,  1'b0, "reset_mie");
        chk(K_NEW,  1'b0, "reset_new_irq");
        chk(K_PEND, 1'b0, "reset_pending");
        rd(3'd4, 32'h0, "reset_mcause");
        rd(3'd2, 32'h0, "reset_mie_reg");

        wr(3'd2, 2'd1, 32'hFFFF_FFFF);
        rd(3'd2, 32'h000F_0888, "mie_write_mask");
        wr(3'd2, 2'd1, 32'h0000_0888);
        rd(3'd2, 32'h0000_0888, "mie_0x888");
        i_mtip = 1'b1;
        rd(3'd3, 32'h0000_0080, "mip_mtip_bit7");
        wr(3'd3, 2'd1, 32'hFFFF_FFFF);
        rd(3'd3, 32'h0000_0080, "mip_write_ignored");
        chk(K_PEND, 1'b0, "pending_masked_by_mie0");

        wr(3'd1, 2'd2, 32'h0000_0008);
        chk(K_MIE,  1'b1, "set_mode_mie");
        chk(K_PEND, 1'b1, "set_mode_pending");
        chk(K_NEW,  1'b1, "set_mode_new_irq");
        wr(3'd1, 2'd3, 32'h0000_0008);
        chk(K_MIE,  1'b0, "clear_mode_mie");
        chk(K_PEND, 1'b0, "clear_mode_pending");
        chk(K_NEW,  1'b0, "clear_mode_new_irq");
        i_mtip = 1'b0;
        wr(3'd1, 2'd1, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0000_0088, "mstatus_write_mask");

        wr(3'd1, 2'd1, 32'h0000_0008);
        i_meip = 1'b1; i_mtip = 1'b1;
        rd(3'd3, 32'h0000_0880, "mip_meip_mtip");
        chk(K_NEW,  1'b1, "irq_meip_new");
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h8000_000B, "mcause_meip");
        rd(3'd1, 32'h0000_0080, "mstatus_after_irq_trap");
        chk(K_MIE,  1'b0, "mie_after_irq_trap");
        chk(K_PEND, 1'b0, "pending_after_irq_trap");
        i_meip = 1'b0; i_mtip = 1'b0;

        wr(3'd1, 2'd1, 32'h0000_0008);
        i_e_op = 1'b1;
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h0000_000B, "mcause_ecall");
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk(K_MIE, 1'b1, "mret_restores_mie");
        rd(3'd1, 32'h0000_0088, "mstatus_after_mret");
        i_ebreak = 1'b1;
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h0000_0003, "mcause_ebreak");
        i_e_op = 1'b0; i_ebreak = 1'b0;
        i_mem_op = 1'b1; i_mem_cmd = 1'b1;
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h0000_0006, "mcause_store_misaligned");
        i_mem_cmd = 1'b0;
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h0000_0004, "mcause_load_misaligned");
        i_mem_op = 1'b0;
        wr(3'd1, 2'd1, 32'h0000_0008);
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        rd(3'd1, 32'h0000_0080, "trap_and_mret_mstatus");
        rd(3'd4, 32'h0000_0000, "trap_and_mret_mcause");

        wr(3'd2, 2'd1, 32'h0004_0000);
        wr(3'd1, 2'd1, 32'h0000_0008);
        i_lirq = 4'b0100;
        rd(3'd3, 32'h0004_0000, "mip_lirq2");
        i_lirq = 4'b0000;
        chk(K_NEW, 1'b1, "lirq2_new_irq");
        word(3'd0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        rd(3'd4, 32'h8000_0012, "mcause_lirq2");

        wr(3'd2, 2'd1, 32'h0000_0888);
        wr(3'd1, 2'd1, 32'h0000_0008);
        i_msip = 1'b1;
        wr(3'd0, 2'd0, 32'd0);
        chk(K_NEW, 1'b1, "level_first_edge");
        wr(3'd0, 2'd0, 32'd0);
        chk(K_NEW, 1'b0, "level_no_rearm");
        wr(3'd2, 2'd1, 32'h0);
        chk(K_PEND, 1'b0, "mie_mask_drops_pending");
        wr(3'd2, 2'd1, 32'h0000_0888);
        chk(K_NEW, 1'b1, "level_rearm_after_drop");
        i_msip = 1'b0;

        wr(3'd4, 2'd1, 32'hFFFF_FFFF);
        rd(3'd4, 32'h8000_001F, "mcause_write_mask");
        for (int i = 0; i <= 10; i++) begin
            i_csr_sel = 3'd4; i_csr_source = 2'd1; i_cnt = 5'(i); i_en = 1'b1; i_d = 1'b1;
            if (i == 10)
                i_rst = 1'b1;
            @(posedge i_clk); #1;
        end
        i_en = 1'b0; i_csr_sel = 3'd0; i_cnt = 5'd0;
        repeat (2) begin @(posedge i_clk); #1; end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        rd(3'd4, 32'h0, "mcause_after_midword_reset");
        chk(K_NEW, 1'b0, "new_irq_after_midword_reset");
        rd(3'd2, 32'h0, "mie_after_midword_reset");

        repeat (2) begin @(posedge i_clk); #1; end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: %0d expectations never observed, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
